// File: rtl/router_pkg.sv
// router_pkg: packet field positions, requester indices and buffer states shared by the router blocks.
package router_pkg;
  localparam int VC_BIT = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB_BIT = 55;
  localparam int HOP_LSB_BIT = 48;
  localparam int SRC_MSB_BIT = 47;
  localparam int SRC_LSB_BIT = 32;
  localparam int PAYLOAD_MSB_BIT = 31;
  localparam int PAYLOAD_LSB_BIT = 0;
  localparam int CW = 0;
  localparam int CCW = 1;
  localparam int PE = 2;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first eligible requester at or after ptr, wrapping modulo N.
module rr_priority_select import router_pkg::*; #(
  parameter int N = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);
  int idx;
  always_comb begin
    grant = '0;
    winner = '0;
    idx = 0;
    // scan from lowest to highest priority so the highest-priority match overwrites
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) begin
        grant = N'(1) << idx;
        winner = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter: per-output-channel arbiter with even/odd VC buffers and polarity-alternated fill/send.
module ring_output_arbiter import router_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 64,
  parameter int HOP_MSB = HOP_MSB_BIT,
  parameter int HOP_LSB = HOP_LSB_BIT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          polarity,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_vc,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          ro,
  output logic                          so,
  output logic [DATA_WIDTH-1:0]         dout
);
  localparam int IW = $clog2(NUM_REQ);
  buf_state_t state_q[2], state_d[2];
  logic [DATA_WIDTH-1:0] buf_q[2], buf_d[2];
  logic [IW-1:0] rr_q[2], rr_d[2];
  logic so_q, so_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, send_pkt;
  logic [NUM_REQ-1:0] eligible, sel_grant;
  logic [IW-1:0] winner;
  logic fill_vc, send_vc;
  assign fill_vc = polarity;
  assign send_vc = ~polarity;
  assign eligible = req & ~(req_vc ^ {NUM_REQ{fill_vc}}) & {NUM_REQ{state_q[fill_vc] == EMPTY}};
  rr_priority_select #(.N(NUM_REQ)) u_sel (
    .eligible,
    .ptr(rr_q[fill_vc]),
    .grant(sel_grant),
    .winner
  );
  assign grant = reset ? '0 : sel_grant;
  assign so = so_q;
  assign dout = dout_q;
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    rr_d = rr_q;
    send_pkt = buf_q[send_vc];
    send_pkt[HOP_MSB:HOP_LSB] = buf_q[send_vc][HOP_MSB:HOP_LSB] >> 1;
    so_d = (state_q[send_vc] == FULL) && ro;
    dout_d = so_d ? send_pkt : dout_q;
    if (so_d) state_d[send_vc] = EMPTY;
    if (|sel_grant) begin
      buf_d[fill_vc] = din[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      state_d[fill_vc] = FULL;
      rr_d[fill_vc] = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '{EMPTY, EMPTY};
      buf_q <= '{default: '0};
      rr_q <= '{default: '0};
      so_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      rr_q <= rr_d;
      so_q <= so_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_ring_output_arbiter.sv
// tb_ring_output_arbiter: directed scenario checks of grant, send strobe and hop update.
module tb_ring_output_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic polarity = 0;
  logic [2:0] req = 0;
  logic [2:0] req_vc = 0;
  logic [191:0] din = 0;
  logic [2:0] grant;
  logic ro = 0;
  logic so;
  logic [63:0] dout;
  int total = 0;
  int passed = 0;

  ring_output_arbiter dut (
    .clk(clk), .reset(reset), .polarity(polarity), .req(req), .req_vc(req_vc),
    .din(din), .grant(grant), .ro(ro), .so(so), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic vc, input logic [7:0] hop, input logic [31:0] pl);
    return {vc, 1'b0, 6'b0, hop, 16'h5A5A, pl};
  endfunction

  function automatic logic [63:0] hopped(input logic [63:0] p);
    logic [63:0] r;
    r = p;
    r[55:48] = p[55:48] >> 1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req = 0; req_vc = 0; ro = 0; polarity = 0; din = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req = 3'b111; req_vc = 3'b000; polarity = 0; ro = 1;
    din[0 +: 64] = mk(0, 8'h07, 32'h1); din[64 +: 64] = mk(0, 8'h07, 32'h2); din[128 +: 64] = mk(0, 8'h07, 32'h3);
    #1;
    total++; if (grant !== 3'b000) $display("FAIL reset_grant got %b exp 000", grant); else passed++;
    tick(); tick();
    total++; if (grant !== 3'b000) $display("FAIL reset_grant_held got %b exp 000", grant); else passed++;
    total++; if (so !== 1'b0) $display("FAIL reset_so got %b exp 0", so); else passed++;
    total++; if (dout !== 64'h0) $display("FAIL reset_dout got %h exp 0", dout); else passed++;
    reset = 0;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL reset_first_grant got %b exp 001", grant); else passed++;
    req = 0;
  endtask

  task automatic test_basic();
    logic [63:0] p;
    do_reset();
    p = mk(0, 8'b00000111, 32'hDEADBEEF);
    polarity = 0; req = 3'b001; req_vc = 3'b000; din[0 +: 64] = p;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL basic_grant got %b exp 001", grant); else passed++;
    tick();
    req = 0; polarity = 1; ro = 1;
    tick();
    total++; if (so !== 1'b1) $display("FAIL basic_so got %b exp 1", so); else passed++;
    total++; if (dout !== mk(0, 8'b00000011, 32'hDEADBEEF)) $display("FAIL basic_dout got %h exp %h", dout, mk(0, 8'b00000011, 32'hDEADBEEF)); else passed++;
    polarity = 0;
    tick();
    total++; if (so !== 1'b0) $display("FAIL basic_so_drop got %b exp 0", so); else passed++;
    total++; if (dout !== mk(0, 8'b00000011, 32'hDEADBEEF)) $display("FAIL basic_dout_hold got %h exp %h", dout, mk(0, 8'b00000011, 32'hDEADBEEF)); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int exp_i [4] = '{0, 1, 2, 0};
    logic [63:0] pk [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pk[i] = mk(0, 8'hFF, 32'h100 + i);
      din[i*64 +: 64] = pk[i];
    end
    ro = 1; req = 3'b111; req_vc = 3'b000;
    for (int k = 0; k < 4; k++) begin
      polarity = 0;
      #1;
      total++; if (grant !== exp_g[k]) $display("FAIL rr_grant_%0d got %b exp %b", k, grant, exp_g[k]); else passed++;
      tick();
      polarity = 1;
      #1;
      total++; if (grant !== 3'b000) $display("FAIL rr_odd_idle_%0d got %b exp 000", k, grant); else passed++;
      tick();
      total++; if (so !== 1'b1) $display("FAIL rr_so_%0d got %b exp 1", k, so); else passed++;
      total++; if (dout !== hopped(pk[exp_i[k]])) $display("FAIL rr_dout_%0d got %h exp %h", k, dout, hopped(pk[exp_i[k]])); else passed++;
    end
    polarity = 1; req_vc = 3'b111;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL rr_odd_ptr got %b exp 001", grant); else passed++;
    req = 0;
  endtask

  task automatic test_vc_separation();
    logic [63:0] a, b;
    do_reset();
    a = mk(1, 8'h0F, 32'hAAAA0000);
    b = mk(0, 8'h00, 32'hBBBB0000);
    ro = 1; polarity = 0; req = 3'b011; req_vc = 3'b001;
    din[0 +: 64] = a; din[64 +: 64] = b;
    #1;
    total++; if (grant !== 3'b010) $display("FAIL vc_even_grant got %b exp 010", grant); else passed++;
    tick();
    req = 3'b001; polarity = 1;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL vc_odd_grant got %b exp 001", grant); else passed++;
    tick();
    req = 0;
    total++; if (so !== 1'b1 || dout !== b) $display("FAIL vc_even_send got so=%b dout=%h exp so=1 dout=%h", so, dout, b); else passed++;
    polarity = 0;
    tick();
    total++; if (so !== 1'b1 || dout !== mk(1, 8'h07, 32'hAAAA0000)) $display("FAIL vc_odd_send got so=%b dout=%h exp so=1 dout=%h", so, dout, mk(1, 8'h07, 32'hAAAA0000)); else passed++;
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    do_reset();
    p = mk(0, 8'h03, 32'hC0FFEE);
    ro = 0; polarity = 0; req = 3'b001; req_vc = 3'b000; din[0 +: 64] = p;
    tick();
    for (int k = 0; k < 4; k++) begin
      polarity = (k % 2 == 0);
      #1;
      if (!polarity) begin
        total++; if (grant !== 3'b000) $display("FAIL bp_grant_blocked_%0d got %b exp 000", k, grant); else passed++;
      end
      tick();
      total++; if (so !== 1'b0) $display("FAIL bp_so_%0d got %b exp 0", k, so); else passed++;
    end
    polarity = 1; ro = 1;
    tick();
    total++; if (so !== 1'b1 || dout !== mk(0, 8'h01, 32'hC0FFEE)) $display("FAIL bp_release got so=%b dout=%h exp so=1 dout=%h", so, dout, mk(0, 8'h01, 32'hC0FFEE)); else passed++;
    polarity = 0;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL bp_grant_resume got %b exp 001", grant); else passed++;
    tick();
    req = 0;
    total++; if (so !== 1'b0) $display("FAIL bp_so_once got %b exp 0", so); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ro = 0; polarity = 0; req = 3'b001; req_vc = 3'b000;
    din[0 +: 64] = mk(0, 8'hFF, 32'h11111111);
    din[64 +: 64] = mk(1, 8'hFF, 32'h22222222);
    tick();
    polarity = 1; req = 3'b010; req_vc = 3'b010;
    #1;
    total++; if (grant !== 3'b010) $display("FAIL mr_odd_fill got %b exp 010", grant); else passed++;
    tick();
    req = 0; reset = 1;
    tick();
    reset = 0;
    total++; if (so !== 1'b0 || dout !== 64'h0) $display("FAIL mr_reset_out got so=%b dout=%h exp so=0 dout=0", so, dout); else passed++;
    ro = 1; polarity = 0;
    tick();
    total++; if (so !== 1'b0) $display("FAIL mr_odd_discarded got %b exp 0", so); else passed++;
    polarity = 1;
    tick();
    total++; if (so !== 1'b0 || dout !== 64'h0) $display("FAIL mr_even_discarded got so=%b dout=%h exp so=0 dout=0", so, dout); else passed++;
    polarity = 0; req = 3'b001; req_vc = 3'b000;
    #1;
    total++; if (grant !== 3'b001) $display("FAIL mr_even_empty got %b exp 001", grant); else passed++;
    req = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_vc_separation();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
